// File: rtl/ppi_strobed_port.sv
// Mode-1 strobed handshake stage for one PPI port: input latch with STB_n/IBF,
// output latch with OBF_n/ACK_n, interrupt request and sticky overrun flag.
module ppi_strobed_port #(
    parameter int          WIDTH       = 8,
    parameter logic [1:0]  PORT_ADDR   = 2'b00,
    parameter int          INTE_BIT    = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic [1:0]       a_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    input  logic             mode_en_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] port_in_i,
    output logic [WIDTH-1:0] port_out_o,
    output logic             port_oe_o,
    input  logic             stb_n_i,
    input  logic             ack_n_i,
    output logic             ibf_o,
    output logic             obf_n_o,
    output logic             intr_o,
    output logic             ovr_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_ACKING} state_t;

    localparam logic [2:0] INTE_SEL = 3'(INTE_BIT);

    state_t                 state_q, state_d;
    logic                   rd_q, wr_q, mode_q, dir_q;
    logic [SYNC_STAGES-1:0] stb_sync_q, ack_sync_q;
    logic                   stb_last_q, ack_last_q;
    logic                   ibf_q, ibf_d, obf_n_q, obf_n_d;
    logic                   intr_q, intr_d, ovr_q, ovr_d;
    logic                   inte_q, inte_d, dout_valid_q, dout_valid_d;
    logic [WIDTH-1:0]       dout_q, dout_d, port_out_q, port_out_d, latch_q, latch_d;

    logic sel, rd_fall, rd_rise, wr_rise, bsr_wr, cfg_chg;
    logic stb_s, ack_s, stb_fall, stb_rise, ack_fall, ack_rise;

    assign sel      = ~cs_i & (a_i == PORT_ADDR);
    assign rd_fall  = sel & rd_q & ~rd_i;
    assign rd_rise  = sel & ~rd_q & rd_i;
    assign wr_rise  = sel & ~wr_q & wr_i;
    assign bsr_wr   = ~cs_i & (a_i == 2'b11) & ~wr_q & wr_i & ~din_i[7] & (din_i[3:1] == INTE_SEL);
    assign cfg_chg  = (mode_en_i != mode_q) | (dir_i != dir_q);

    assign stb_s    = stb_sync_q[SYNC_STAGES-1];
    assign ack_s    = ack_sync_q[SYNC_STAGES-1];
    assign stb_fall = stb_last_q & ~stb_s;
    assign stb_rise = ~stb_last_q & stb_s;
    assign ack_fall = ack_last_q & ~ack_s;
    assign ack_rise = ~ack_last_q & ack_s;

    always_comb begin
        state_d      = state_q;
        ibf_d        = ibf_q;
        obf_n_d      = obf_n_q;
        intr_d       = intr_q;
        ovr_d        = ovr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        port_out_d   = port_out_q;
        latch_d      = latch_q;
        inte_d       = bsr_wr ? din_i[0] : inte_q;

        // Clearing INTE drops a pending request; a same-edge set event below
        // still sees the old INTE and takes priority.
        if (bsr_wr && !din_i[0])
            intr_d = 1'b0;

        if (!mode_en_i || cfg_chg) begin
            state_d = ST_IDLE;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
            ovr_d   = 1'b0;
        end else if (dir_i) begin
            if (rd_fall) begin
                dout_d       = latch_q;
                dout_valid_d = 1'b1;
                intr_d       = 1'b0;
                ovr_d        = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (stb_fall) begin
                        latch_d = port_in_i;
                        ibf_d   = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (stb_rise)
                        intr_d = inte_q;
                    // A strobe landing on the read-release edge refills the buffer.
                    if (stb_fall && rd_rise)
                        latch_d = port_in_i;
                    else if (stb_fall)
                        ovr_d = 1'b1;
                    else if (rd_rise) begin
                        ibf_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            if (rd_fall) begin
                dout_d       = port_out_q;
                dout_valid_d = 1'b1;
            end
            if (wr_rise) begin
                port_out_d = din_i;
                obf_n_d    = 1'b0;
                intr_d     = 1'b0;
                state_d    = ST_FULL;
            end else begin
                case (state_q)
                    ST_FULL: begin
                        if (ack_fall) begin
                            obf_n_d = 1'b1;
                            state_d = ST_ACKING;
                        end
                    end
                    ST_ACKING: begin
                        if (ack_rise) begin
                            intr_d  = inte_q;
                            state_d = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rd_q         <= 1'b1;
            wr_q         <= 1'b1;
            mode_q       <= mode_en_i;
            dir_q        <= dir_i;
            stb_sync_q   <= '1;
            ack_sync_q   <= '1;
            stb_last_q   <= 1'b1;
            ack_last_q   <= 1'b1;
            ibf_q        <= 1'b0;
            obf_n_q      <= 1'b1;
            intr_q       <= 1'b0;
            ovr_q        <= 1'b0;
            inte_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            port_out_q   <= '0;
            latch_q      <= '0;
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_i;
            wr_q          <= wr_i;
            mode_q        <= mode_en_i;
            dir_q         <= dir_i;
            stb_sync_q[0] <= stb_n_i;
            ack_sync_q[0] <= ack_n_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stb_sync_q[i] <= stb_sync_q[i-1];
                ack_sync_q[i] <= ack_sync_q[i-1];
            end
            stb_last_q    <= stb_s;
            ack_last_q    <= ack_s;
            ibf_q         <= ibf_d;
            obf_n_q       <= obf_n_d;
            intr_q        <= intr_d;
            ovr_q         <= ovr_d;
            inte_q        <= inte_d;
            dout_valid_q  <= dout_valid_d;
            dout_q        <= dout_d;
            port_out_q    <= port_out_d;
            latch_q       <= latch_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign port_out_o   = port_out_q;
    assign port_oe_o    = mode_en_i & ~dir_i;
    assign ibf_o        = ibf_q;
    assign obf_n_o      = obf_n_q;
    assign intr_o       = intr_q;
    assign ovr_o        = ovr_q;

endmodule
